// File: rtl/matrix_operand_loader_if.sv
// Operand-loader bus: element-pair handshake in, packed operand and engine control out.
// master = upstream feeder/engine side, slave = the loader itself.
interface matrix_operand_loader_if #(
    parameter int unsigned ELEM_W = 16
);
    logic [ELEM_W-1:0]   a_data;
    logic [ELEM_W-1:0]   b_data;
    logic                a_valid;
    logic                b_valid;
    logic                a_ready;
    logic                b_ready;
    logic [2*ELEM_W-1:0] out_word;
    logic                data_RW;
    logic                dp_reset;
    logic                busy;
    logic                done;

    modport master (
        output a_data, b_data, a_valid, b_valid,
        input  a_ready, b_ready, out_word, data_RW, dp_reset, busy, done
    );

    modport slave (
        input  a_data, b_data, a_valid, b_valid,
        output a_ready, b_ready, out_word, data_RW, dp_reset, busy, done
    );
endinterface

// File: rtl/matrix_operand_loader.sv
// Buffers one matrix pair, replays it as {b,a} words in descending index order with
// data_RW=1, then pulses the engine clear and times the compute window.
module matrix_operand_loader #(
    parameter int unsigned ELEM_W         = 16,
    parameter int unsigned N_ELEM         = 9,
    parameter int unsigned COMPUTE_CYCLES = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    matrix_operand_loader_if.slave  bus
);
    localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned CNT_W = $clog2(COMPUTE_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COMPUTE_CYCLES);

    typedef enum logic [1:0] {StFill, StLoad, StClear, StCompute} state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [2*ELEM_W-1:0] r_word, w_word_nxt;
    logic                r_rw, w_rw_nxt;
    logic                r_dpr, w_dpr_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_ready, w_ready_nxt;
    logic                w_accept;

    logic [ELEM_W-1:0]   r_a_buf [N_ELEM];
    logic [ELEM_W-1:0]   r_b_buf [N_ELEM];

    // r_ready is only ever high in StFill, so it alone qualifies the handshake.
    assign w_accept = r_ready && bus.a_valid && bus.b_valid;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a_buf[r_idx] <= bus.a_data;
            r_b_buf[r_idx] <= bus.b_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        w_rw_nxt    = r_rw;
        w_dpr_nxt   = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_ready_nxt = r_ready;
        case (r_state)
            StFill: begin
                w_ready_nxt = 1'b1;
                if (w_accept) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = StLoad;
                        w_ready_nxt = 1'b0;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            StLoad: begin
                // Pair LAST_IDX was written on the entry edge and is readable here.
                w_word_nxt = {r_b_buf[r_idx], r_a_buf[r_idx]};
                w_rw_nxt   = 1'b1;
                if (r_idx == '0) begin
                    w_state_nxt = StClear;
                end else begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                end
            end
            StClear: begin
                w_word_nxt  = '0;
                w_rw_nxt    = 1'b0;
                w_dpr_nxt   = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = StCompute;
            end
            StCompute: begin
                if (r_cnt == LAST_CNT) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_ready_nxt = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = StFill;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = StFill;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StFill;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_rw    <= 1'b0;
            r_dpr   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
            r_rw    <= w_rw_nxt;
            r_dpr   <= w_dpr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    assign bus.a_ready  = r_ready;
    assign bus.b_ready  = r_ready;
    assign bus.out_word = r_word;
    assign bus.data_RW  = r_rw;
    assign bus.dp_reset = r_dpr;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
endmodule
